// File: rtl/mipi_dsi_lane_ctrl.sv
// mipi_dsi_lane_ctrl: D-PHY TX burst sequencer (LP-11 -> HS -> LP-11) for one clock lane plus LANE_WIDTH data lanes.
// Ports: tx_byte_clk/tx_rst (async active-high) clock and reset; hs_req starts a burst;
// hs_data/hs_valid/hs_last/hs_rdy form the payload handshake; busy flags a burst in progress;
// underrun pulses when payload runs dry; tx_hs_c_flag/tx_lp_clk_p/tx_lp_clk_n drive the clock lane;
// tx_hs_d_flag/tx_lp_data_p/tx_lp_data_n/tx_hs_data drive the data lanes.
module mipi_dsi_lane_ctrl #(
  parameter int LANE_WIDTH = 4,
  parameter int BUS_WIDTH = 8 * LANE_WIDTH,
  parameter logic [7:0] T_CLK_LPX = 8'd2,
  parameter logic [7:0] T_CLK_PREP = 8'd2,
  parameter logic [7:0] T_CLK_ZERO = 8'd8,
  parameter logic [7:0] T_CLK_PRE = 8'd2,
  parameter logic [7:0] T_LPX = 8'd2,
  parameter logic [7:0] T_HS_PREP = 8'd2,
  parameter logic [7:0] T_HS_ZERO = 8'd6,
  parameter logic [7:0] T_HS_TRAIL = 8'd3,
  parameter logic [7:0] T_CLK_POST = 8'd4,
  parameter logic [7:0] T_CLK_TRAIL = 8'd3,
  parameter logic [7:0] T_HS_EXIT = 8'd4
) (
  input  logic                  tx_byte_clk,
  input  logic                  tx_rst,
  input  logic                  hs_req,
  input  logic [BUS_WIDTH-1:0]  hs_data,
  input  logic                  hs_valid,
  input  logic                  hs_last,
  output logic                  hs_rdy,
  output logic                  busy,
  output logic                  underrun,
  output logic                  tx_hs_c_flag,
  output logic                  tx_lp_clk_p,
  output logic                  tx_lp_clk_n,
  output logic [LANE_WIDTH-1:0] tx_hs_d_flag,
  output logic [LANE_WIDTH-1:0] tx_lp_data_p,
  output logic [LANE_WIDTH-1:0] tx_lp_data_n,
  output logic [BUS_WIDTH-1:0]  tx_hs_data
);
  // Encoding order matters: the HS/LP decodes below use range compares.
  typedef enum logic [3:0] {
    STOP, CLK_LPX, CLK_PREP, CLK_ZERO, CLK_PRE, D_LPX, D_PREP, D_ZERO,
    D_SYNC, D_DATA, D_TRAIL, CLK_POST, CLK_TRAIL, EXIT
  } state_t;
  state_t state, nxt;
  logic [8:0] cnt, ld;
  logic [LANE_WIDTH-1:0] msb, data_msb;
  logic [BUS_WIDTH-1:0] trail;
  logic done, beat;
  function automatic logic [8:0] len(input logic [7:0] t);
    return (t == 8'd0) ? 9'd0 : {1'b0, t} - 9'd1;
  endfunction
  assign done = cnt == 9'd0;
  assign hs_rdy = state == D_DATA;
  assign busy = state != STOP;
  assign beat = hs_rdy && hs_valid;
  for (genvar i = 0; i < LANE_WIDTH; i++) begin : g_lane
    assign data_msb[i] = hs_data[8*i+7];
    assign trail[8*i +: 8] = {8{~msb[i]}};
  end
  always_comb begin
    nxt = state;
    case (state)
      STOP:      nxt = hs_req ? CLK_LPX : STOP;
      CLK_LPX:   nxt = done ? CLK_PREP : state;
      CLK_PREP:  nxt = done ? CLK_ZERO : state;
      CLK_ZERO:  nxt = done ? CLK_PRE : state;
      CLK_PRE:   nxt = done ? D_LPX : state;
      D_LPX:     nxt = done ? D_PREP : state;
      D_PREP:    nxt = done ? D_ZERO : state;
      D_ZERO:    nxt = done ? D_SYNC : state;
      D_SYNC:    nxt = D_DATA;
      D_DATA:    nxt = (!hs_valid || hs_last) ? D_TRAIL : D_DATA;
      D_TRAIL:   nxt = done ? CLK_POST : state;
      CLK_POST:  nxt = done ? CLK_TRAIL : state;
      CLK_TRAIL: nxt = done ? EXIT : state;
      EXIT:      nxt = done ? STOP : state;
      default:   nxt = STOP;
    endcase
  end
  // A trail entered on the last beat is one cycle longer: its first cycle still carries that beat.
  always_comb begin
    ld = 9'd0;
    case (nxt)
      CLK_LPX:   ld = len(T_CLK_LPX);
      CLK_PREP:  ld = len(T_CLK_PREP);
      CLK_ZERO:  ld = len(T_CLK_ZERO);
      CLK_PRE:   ld = len(T_CLK_PRE);
      D_LPX:     ld = len(T_LPX);
      D_PREP:    ld = len(T_HS_PREP);
      D_ZERO:    ld = len(T_HS_ZERO);
      D_TRAIL:   ld = len(T_HS_TRAIL) + {8'd0, beat};
      CLK_POST:  ld = len(T_CLK_POST);
      CLK_TRAIL: ld = len(T_CLK_TRAIL);
      EXIT:      ld = len(T_HS_EXIT);
      default:   ld = 9'd0;
    endcase
  end
  always_ff @(posedge tx_byte_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state <= STOP;
      cnt <= 9'd0;
      msb <= '1;
      underrun <= 1'b0;
      tx_hs_c_flag <= 1'b0;
      tx_lp_clk_p <= 1'b1;
      tx_lp_clk_n <= 1'b1;
      tx_hs_d_flag <= '0;
      tx_lp_data_p <= '1;
      tx_lp_data_n <= '1;
      tx_hs_data <= '0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? ld : (done ? 9'd0 : cnt - 9'd1);
      underrun <= hs_rdy && !hs_valid;
      tx_hs_c_flag <= nxt >= CLK_ZERO && nxt <= CLK_TRAIL;
      tx_lp_clk_p <= nxt == STOP || nxt == EXIT;
      tx_lp_clk_n <= nxt == STOP || nxt == EXIT || nxt == CLK_LPX;
      tx_hs_d_flag <= {LANE_WIDTH{nxt >= D_ZERO && nxt <= D_TRAIL}};
      tx_lp_data_p <= {LANE_WIDTH{nxt < D_LPX || nxt > D_TRAIL}};
      tx_lp_data_n <= {LANE_WIDTH{nxt < D_PREP || nxt > D_TRAIL}};
      // msb tracks bit 7 of the last byte sent per lane so the trail can invert it.
      if (beat) begin
        tx_hs_data <= hs_data;
        msb <= data_msb;
      end else if (nxt == D_SYNC) begin
        tx_hs_data <= {LANE_WIDTH{8'hB8}};
        msb <= '1;
      end else if (nxt == D_TRAIL) begin
        tx_hs_data <= trail;
      end else if (nxt != D_DATA) begin
        tx_hs_data <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mipi_dsi_lane_ctrl.sv
// tb_mipi_dsi_lane_ctrl: randomized burst stimulus checked cycle by cycle against a timeline model of the D-PHY burst.
module tb_mipi_dsi_lane_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic hs_req = 1'b0, hs_valid = 1'b0, hs_last = 1'b0, hs_req_b = 1'b0;
  logic [31:0] hs_data = '0;
  logic rdy_a, busy_a, und_a, hsc_a, cp_a, cn_a, rdy_b, busy_b, und_b, hsc_b, cp_b, cn_b;
  logic [3:0] hsd_a, dp_a, dn_a, hsd_b, dp_b, dn_b;
  logic [31:0] txd_a, txd_b;
  logic [17:0] ctl_a, ctl_b;
  assign ctl_a = {busy_a, rdy_a, und_a, hsc_a, cp_a, cn_a, hsd_a, dp_a, dn_a};
  assign ctl_b = {busy_b, rdy_b, und_b, hsc_b, cp_b, cn_b, hsd_b, dp_b, dn_b};
  mipi_dsi_lane_ctrl dut_a (
    .tx_byte_clk(clk), .tx_rst(rst), .hs_req(hs_req), .hs_data(hs_data), .hs_valid(hs_valid),
    .hs_last(hs_last), .hs_rdy(rdy_a), .busy(busy_a), .underrun(und_a), .tx_hs_c_flag(hsc_a),
    .tx_lp_clk_p(cp_a), .tx_lp_clk_n(cn_a), .tx_hs_d_flag(hsd_a), .tx_lp_data_p(dp_a),
    .tx_lp_data_n(dn_a), .tx_hs_data(txd_a)
  );
  mipi_dsi_lane_ctrl #(.T_CLK_ZERO(8'd0), .T_HS_ZERO(8'd0), .T_HS_TRAIL(8'd0), .T_HS_EXIT(8'd0)) dut_b (
    .tx_byte_clk(clk), .tx_rst(rst), .hs_req(hs_req_b), .hs_data(32'd0), .hs_valid(1'b0),
    .hs_last(1'b0), .hs_rdy(rdy_b), .busy(busy_b), .underrun(und_b), .tx_hs_c_flag(hsc_b),
    .tx_lp_clk_p(cp_b), .tx_lp_clk_n(cn_b), .tx_hs_d_flag(hsd_b), .tx_lp_data_p(dp_b),
    .tx_lp_data_n(dn_b), .tx_hs_data(txd_b)
  );
  typedef struct {logic [17:0] ctl; logic [31:0] data; bit dchk;} rec_t;
  rec_t exp_q[$];
  logic [31:0] words[$];
  int n_chk = 0, n_err = 0;
  int prm_a[11] = '{2, 2, 8, 2, 2, 2, 6, 3, 4, 3, 4};
  int prm_b[11] = '{2, 2, 0, 2, 2, 2, 0, 0, 4, 3, 0};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int e(input int v);
    return v == 0 ? 1 : v;
  endfunction
  function automatic logic [17:0] mk(input bit bsy, rdy, und, hsc, input logic [1:0] clp, input bit hsd, input logic [1:0] dlp);
    return {bsy, rdy, und, hsc, clp, {4{hsd}}, {4{dlp[1]}}, {4{dlp[0]}}};
  endfunction
  task automatic push(input int n, input logic [17:0] c, input logic [31:0] d, input bit dc);
    rec_t r;
    r.ctl = c;
    r.data = d;
    r.dchk = dc;
    repeat (n) exp_q.push_back(r);
  endtask
  // Expected per-cycle outputs of one burst, starting the cycle after hs_req is sampled.
  task automatic build(input int p[11], input int und_at);
    logic [31:0] last, t;
    bit u = 0;
    exp_q.delete();
    push(e(p[0]), mk(1, 0, 0, 0, 2'b01, 0, 2'b11), 0, 0);
    push(e(p[1]), mk(1, 0, 0, 0, 2'b00, 0, 2'b11), 0, 0);
    push(e(p[2]) + e(p[3]), mk(1, 0, 0, 1, 2'b00, 0, 2'b11), 0, 0);
    push(e(p[4]), mk(1, 0, 0, 1, 2'b00, 0, 2'b01), 0, 0);
    push(e(p[5]), mk(1, 0, 0, 1, 2'b00, 0, 2'b00), 0, 0);
    push(e(p[6]), mk(1, 0, 0, 1, 2'b00, 1, 2'b00), 0, 1);
    push(1, mk(1, 0, 0, 1, 2'b00, 1, 2'b00), 32'hB8B8B8B8, 1);
    last = 32'hB8B8B8B8;
    for (int k = 0; k < words.size(); k++) begin
      push(1, mk(1, 1, 0, 1, 2'b00, 1, 2'b00), last, k > 0);
      if (k == und_at) begin
        u = 1;
        break;
      end
      last = words[k];
      if (k == words.size() - 1) push(1, mk(1, 0, 0, 1, 2'b00, 1, 2'b00), last, 1);
    end
    for (int i = 0; i < 4; i++) t[8*i +: 8] = {8{~last[8*i+7]}};
    push(1, mk(1, 0, u, 1, 2'b00, 1, 2'b00), t, 1);
    push(e(p[7]) - 1, mk(1, 0, 0, 1, 2'b00, 1, 2'b00), t, 1);
    push(e(p[8]) + e(p[9]), mk(1, 0, 0, 1, 2'b00, 0, 2'b11), 0, 0);
    push(e(p[10]), mk(1, 0, 0, 0, 2'b11, 0, 2'b11), 0, 0);
    push(1, mk(0, 0, 0, 0, 2'b11, 0, 2'b11), 0, 0);
  endtask
  // Caller has hs_req high in a STOP cycle; the first edge here samples it.
  task automatic run(input bit b, input int p[11], input int und_at, input bit keep, input int stop_at);
    int ds, nb;
    build(p, und_at);
    ds = e(p[0]) + e(p[1]) + e(p[2]) + e(p[3]) + e(p[4]) + e(p[5]) + e(p[6]) + 1;
    nb = und_at >= 0 ? und_at + 1 : words.size();
    for (int i = 0; i < exp_q.size() && i < stop_at; i++) begin
      @(posedge clk);
      #1;
      if (b) hs_req_b = keep;
      else hs_req = keep;
      if (i >= ds && i < ds + nb) begin
        hs_valid = (i - ds) != und_at;
        hs_data = words[i-ds];
        hs_last = (i - ds) == words.size() - 1;
      end else begin
        hs_valid = 1'b0;
        hs_data = $urandom;
        hs_last = 1'($urandom_range(0, 1));
      end
      #1;
      check($sformatf("%s ctl[%0d]", b ? "B" : "A", i), 64'(b ? ctl_b : ctl_a), 64'(exp_q[i].ctl));
      if (exp_q[i].dchk) check($sformatf("%s data[%0d]", b ? "B" : "A", i), 64'(b ? txd_b : txd_a), 64'(exp_q[i].data));
    end
    hs_valid = 1'b0;
  endtask
  task automatic start(input bit b);
    @(posedge clk);
    #1;
    if (b) hs_req_b = 1'b1;
    else hs_req = 1'b1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset ctl", 64'(ctl_a), 64'(mk(0, 0, 0, 0, 2'b11, 0, 2'b11)));
    check("reset data", 64'(txd_a), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("idle[%0d]", i), 64'(ctl_a), 64'(mk(0, 0, 0, 0, 2'b11, 0, 2'b11)));
    end
    words = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    start(0);
    run(0, prm_a, -1, 0, 1000);
    words = '{32'h7F00FF80};
    start(0);
    run(0, prm_a, -1, 0, 1000);
    words = '{32'h0A0B8C8D, 32'h12345678, 32'hDEADBEEF};
    start(0);
    run(0, prm_a, 1, 0, 1000);
    words = '{32'hF0E1D2C3, 32'h01020304};
    start(0);
    run(0, prm_a, -1, 1, 1000);
    run(0, prm_a, -1, 0, 1000);
    for (int r = 0; r < 6; r++) begin
      int n, u;
      n = $urandom_range(1, 5);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back($urandom);
      u = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      start(0);
      run(0, prm_a, u, 0, 1000);
    end
    words = '{32'h0};
    start(1);
    run(1, prm_b, 0, 1, 1000);
    run(1, prm_b, 0, 0, 1000);
    words = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    start(0);
    run(0, prm_a, -1, 0, 27);
    #1 rst = 1'b1;
    #1;
    check("async reset ctl", 64'(ctl_a), 64'(mk(0, 0, 0, 0, 2'b11, 0, 2'b11)));
    check("async reset data", 64'(txd_a), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("after reset ctl", 64'(ctl_a), 64'(mk(0, 0, 0, 0, 2'b11, 0, 2'b11)));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
